// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: selects a pixel source per frame and turns its pixel
// stream into linear RAM writes that place a COLS x ROWS window inside the frame buffer.
module fb_write_ctrl #(
   parameter int COLS    = 320,
   parameter int ROWS    = 240,
   parameter int FB_COLS = 640,
   parameter int X_OFF   = 160,
   parameter int Y_OFF   = 120,
   parameter int AW      = 19,
   parameter int DW      = 12
) (
   input  logic          clkMain,
   input  logic          rstMain,
   input  logic          frame_start,
   input  logic          bypass_req,
   input  logic          cam_valid,
   input  logic [DW-1:0] cam_data,
   input  logic          flt_valid,
   input  logic [DW-1:0] flt_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          bypass_act,
   output logic          busy,
   output logic          frame_done,
   output logic          short_frame,
   output logic [7:0]    frame_cnt
);

   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);
   localparam logic [AW-1:0] A0       = AW'(Y_OFF * FB_COLS + X_OFF);
   // Jump from the last pixel of a line to the first pixel of the next line.
   localparam logic [AW-1:0] ROW_STEP = AW'(FB_COLS - COLS + 1);

   if (X_OFF + COLS > FB_COLS) begin : g_bad_x
      $error("fb_write_ctrl: window does not fit in the frame-buffer line");
   end
   if (longint'(Y_OFF + ROWS) * longint'(FB_COLS) > (longint'(1) << AW)) begin : g_bad_y
      $error("fb_write_ctrl: window exceeds the write-address range");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d, cur_x;
   logic [YW-1:0]   y_q, y_d, cur_y;
   logic [AW-1:0]   addr_q, addr_d, cur_addr;
   logic            bypass_q, bypass_d, src;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            short_q, short_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            run, restart, pix_valid;
   logic [DW-1:0]   pix_data;

   // Next-state, address generation and output decode.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = addr_q;
      bypass_d  = bypass_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      short_d   = short_q;
      cnt_d     = cnt_q;
      run       = 1'b0;
      restart   = 1'b0;
      cur_x     = x_q;
      cur_y     = y_q;
      cur_addr  = addr_q;
      src       = bypass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (frame_start) begin
               run     = 1'b1;
               restart = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACTIVE: begin
            run = 1'b1;
            if (frame_start) begin
               restart = 1'b1;
               short_d = 1'b1;
            end else begin
               restart = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A start rewinds to (0,0) and the coincident pixel already uses the new source.
      if (restart) begin
         src      = bypass_req;
         bypass_d = bypass_req;
         cur_x    = '0;
         cur_y    = '0;
         cur_addr = A0;
         state_d  = S_ACTIVE;
      end else begin
         src = bypass_q;
      end

      pix_valid = src ? cam_valid : flt_valid;
      pix_data  = src ? cam_data  : flt_data;

      if (run && pix_valid) begin
         wr_en_d   = 1'b1;
         wr_addr_d = cur_addr;
         wr_data_d = pix_data;
         if (cur_x == X_LAST) begin
            x_d    = '0;
            addr_d = cur_addr + ROW_STEP;
            if (cur_y == Y_LAST) begin
               y_d     = '0;
               state_d = S_DONE;
               done_d  = 1'b1;
               cnt_d   = cnt_q + 8'd1;
            end else begin
               y_d = cur_y + YW'(1);
            end
         end else begin
            x_d    = cur_x + XW'(1);
            y_d    = cur_y;
            addr_d = cur_addr + AW'(1);
         end
      end else if (run) begin
         x_d    = cur_x;
         y_d    = cur_y;
         addr_d = cur_addr;
      end else begin
         x_d = x_q;
      end

      busy_d = (state_d == S_ACTIVE);
   end

   // State and registered outputs.
   always_ff @(posedge clkMain) begin
      if (rstMain) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         addr_q    <= '0;
         bypass_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         short_q   <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         addr_q    <= addr_d;
         bypass_q  <= bypass_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         short_q   <= short_d;
         cnt_q     <= cnt_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign bypass_act  = bypass_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign short_frame = short_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: a small-window instance for full-frame and corner sequences,
// plus a default-parameter instance for the nominal placement addresses.
module tb_fb_write_ctrl;

   localparam int C   = 8;
   localparam int R   = 4;
   localparam int FBC = 16;
   localparam int XO  = 4;
   localparam int YO  = 3;
   localparam int SAW = 10;
   localparam int A0S = YO * FBC + XO;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, fs, br, cv, fv;
   logic [11:0] cd, fd;
   logic we, bact, bsy, done, shrt;
   logic [SAW-1:0] addr;
   logic [11:0] data;
   logic [7:0] cnt;

   logic d_fs, d_cv, d_we, d_bact, d_bsy, d_done, d_shrt;
   logic [11:0] d_cd, d_data;
   logic [18:0] d_addr;
   logic [7:0] d_cnt;

   int errors = 0;
   int checks = 0;

   fb_write_ctrl #(.COLS(C), .ROWS(R), .FB_COLS(FBC), .X_OFF(XO), .Y_OFF(YO),
                   .AW(SAW), .DW(12)) dut (
      .clkMain(clk), .rstMain(rst), .frame_start(fs), .bypass_req(br),
      .cam_valid(cv), .cam_data(cd), .flt_valid(fv), .flt_data(fd),
      .wr_en(we), .wr_addr(addr), .wr_data(data), .bypass_act(bact),
      .busy(bsy), .frame_done(done), .short_frame(shrt), .frame_cnt(cnt));

   fb_write_ctrl dut_def (
      .clkMain(clk), .rstMain(rst), .frame_start(d_fs), .bypass_req(1'b1),
      .cam_valid(d_cv), .cam_data(d_cd), .flt_valid(1'b0), .flt_data(12'h000),
      .wr_en(d_we), .wr_addr(d_addr), .wr_data(d_data), .bypass_act(d_bact),
      .busy(d_bsy), .frame_done(d_done), .short_frame(d_shrt), .frame_cnt(d_cnt));

   typedef struct {
      logic        fs, br, cv;
      logic [11:0] cd;
      logic        fv;
      logic [11:0] fd;
      logic        e_we;
      logic [SAW-1:0] e_addr;
      logic [11:0] e_data;
      logic        e_busy, e_done, e_bact;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fs = 1'b0; br = 1'b0; cv = 1'b0; fv = 1'b0; cd = 12'h000; fd = 12'h000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   // Drive n pixels from both sources, frame_start on the first, and check every write.
   task automatic frame_px(input logic src_cam, input int n, input int seed);
      int x, y;
      logic [11:0] cval, fval;
      for (int i = 0; i < n; i++) begin
         cval = 12'(seed + i);
         fval = 12'(12'hFFF - (seed + i));
         fs = (i == 0); br = src_cam; cv = 1'b1; fv = 1'b1; cd = cval; fd = fval;
         tick();
         x = i % C;
         y = i / C;
         chk("px_we",   {31'd0, we}, 32'd1);
         chk("px_addr", {22'd0, addr}, 32'(A0S + y * FBC + x));
         chk("px_data", {20'd0, data}, {20'd0, src_cam ? cval : fval});
         chk("px_done", {31'd0, done}, {31'd0, (i == C * R - 1)});
         chk("px_busy", {31'd0, bsy}, {31'd0, (i != C * R - 1)});
         chk("px_bact", {31'd0, bact}, {31'd0, src_cam});
      end
      fs = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      d_fs = 1'b0; d_cv = 1'b0; d_cd = 12'h000;

      do_reset();
      tick();
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_addr", {22'd0, addr}, 32'd0);
      chk("rst_data", {20'd0, data}, 32'd0);
      chk("rst_flags", {27'd0, bact, bsy, done, shrt, 1'b0}, 32'd0);
      chk("rst_cnt", {24'd0, cnt}, 32'd0);

      // fs br cv cd fv fd | we addr data busy done bact
      vt[0] = '{1'b0, 1'b0, 1'b1, 12'hAAA, 1'b1, 12'hBBB, 1'b0, 10'd0,  12'h000, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b1, 12'h222, 1'b1, 12'h111, 1'b1, 10'd52, 12'h111, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 1'b1, 12'h333, 1'b0, 12'h000, 1'b0, 10'd52, 12'h111, 1'b1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b1, 12'h555, 1'b1, 12'h444, 1'b1, 10'd53, 12'h444, 1'b1, 1'b0, 1'b0};
      vt[4] = '{1'b1, 1'b1, 1'b1, 12'h666, 1'b1, 12'h777, 1'b1, 10'd52, 12'h666, 1'b1, 1'b0, 1'b1};
      vt[5] = '{1'b0, 1'b0, 1'b1, 12'h888, 1'b1, 12'h999, 1'b1, 10'd53, 12'h888, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         fs = vt[i].fs; br = vt[i].br; cv = vt[i].cv; cd = vt[i].cd;
         fv = vt[i].fv; fd = vt[i].fd;
         tick();
         chk($sformatf("v%0d_we", i),   {31'd0, we},   {31'd0, vt[i].e_we});
         chk($sformatf("v%0d_addr", i), {22'd0, addr}, {22'd0, vt[i].e_addr});
         chk($sformatf("v%0d_data", i), {20'd0, data}, {20'd0, vt[i].e_data});
         chk($sformatf("v%0d_busy", i), {31'd0, bsy},  {31'd0, vt[i].e_busy});
         chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vt[i].e_done});
         chk($sformatf("v%0d_bact", i), {31'd0, bact}, {31'd0, vt[i].e_bact});
      end
      chk("trunc_short", {31'd0, shrt}, 32'd1);
      chk("trunc_cnt", {24'd0, cnt}, 32'd0);

      // Full camera frame, then pixels in DONE and IDLE without a start are dropped.
      do_reset();
      frame_px(1'b1, C * R, 100);
      chk("full_cnt_at_done", {24'd0, cnt}, 32'd1);
      idle_inputs(); cv = 1'b1; fv = 1'b1; br = 1'b1;
      tick();
      chk("drop_done_we", {31'd0, we}, 32'd0);
      chk("drop_done_pulse", {31'd0, done}, 32'd0);
      tick();
      chk("drop_idle_we", {31'd0, we}, 32'd0);
      chk("full_cnt", {24'd0, cnt}, 32'd1);
      chk("full_bact", {31'd0, bact}, 32'd1);
      chk("full_short", {31'd0, shrt}, 32'd0);

      // Filter source, two frames chained through the DONE cycle.
      do_reset();
      frame_px(1'b0, C * R, 7);
      frame_px(1'b0, C * R, 900);
      idle_inputs();
      tick();
      chk("chain_cnt", {24'd0, cnt}, 32'd2);
      chk("chain_busy", {31'd0, bsy}, 32'd0);

      // Truncate, then reset mid-frame with a pixel pending.
      do_reset();
      frame_px(1'b1, 5, 20);
      frame_px(1'b1, 5, 40);
      chk("mid_short", {31'd0, shrt}, 32'd1);
      rst = 1'b1; cv = 1'b1; fv = 1'b1;
      tick();
      chk("mrst_we", {31'd0, we}, 32'd0);
      chk("mrst_addr", {22'd0, addr}, 32'd0);
      chk("mrst_data", {20'd0, data}, 32'd0);
      chk("mrst_flags", {28'd0, bact, bsy, done, shrt}, 32'd0);
      chk("mrst_cnt", {24'd0, cnt}, 32'd0);
      rst = 1'b0;
      frame_px(1'b0, 3, 60);

      // Default geometry: nominal placement addresses.
      idle_inputs();
      do_reset();
      for (int i = 0; i < 321; i++) begin
         d_fs = (i == 0); d_cv = 1'b1; d_cd = 12'(i + 5);
         tick();
         if (i == 0) begin
            chk("def_first_addr", {13'd0, d_addr}, 32'd76960);
            chk("def_first_data", {20'd0, d_data}, 32'd5);
            chk("def_busy", {31'd0, d_bsy}, 32'd1);
         end else if (i == 319) begin
            chk("def_eol_addr", {13'd0, d_addr}, 32'd77279);
         end else if (i == 320) begin
            chk("def_line1_addr", {13'd0, d_addr}, 32'd77600);
            chk("def_line1_we", {31'd0, d_we}, 32'd1);
         end else begin
            d_fs = 1'b0;
         end
      end
      d_fs = 1'b0; d_cv = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Frame-buffer write controller between the pixel sources (camera path and image filter) and the write port of the dual-port frame RAM. It selects one source per frame, counts pixels into a COLS×ROWS window, and generates linear RAM write addresses that place that window at a fixed offset inside an FB_COLS×FB_ROWS buffer. It also reports frame completion and truncated frames. Address generation is incremental: no multiplier in the datapath.

## Interface
Parameters:
- COLS, 320, active image width in pixels
- ROWS, 240, active image height in lines
- FB_COLS, 640, frame-buffer line pitch in words
- X_OFF, 160, horizontal placement offset
- Y_OFF, 120, vertical placement offset
- AW, 19, write-address width
- DW, 12, pixel width (RGB444)

Ports:
- clkMain  in  1  pixel-domain clock; one clock, all logic on rising edge
- rstMain  in  1  reset, synchronous, active-high
- frame_start  in  1  single-cycle start-of-frame pulse
- bypass_req  in  1  1 = camera source, 0 = filter source; sampled only at frame_start
- cam_valid  in  1  camera pixel strobe
- cam_data  in  DW  camera pixel
- flt_valid  in  1  filter pixel strobe
- flt_data  in  DW  filter pixel
- wr_en  out  1  RAM write enable
- wr_addr  out  AW  RAM write address
- wr_data  out  DW  RAM write data
- bypass_act  out  1  source latched for the current frame
- busy  out  1  high while in ACTIVE
- frame_done  out  1  single-cycle pulse on frame completion
- short_frame  out  1  sticky: a frame restarted before completion
- frame_cnt  out  8  completed-frame counter, wraps 255→0

## Operation
- States: IDLE, ACTIVE, DONE. Reset → IDLE.
- Source selection: pix_valid/pix_data = bypass_act ? cam_* : flt_*. The unselected source is ignored.
- IDLE, frame_start=1:
  - latch bypass_act ← bypass_req
  - set x=0, y=0, next address A0 = (Y_OFF)·FB_COLS + X_OFF, computed at elaboration
  - go to ACTIVE
- Coincident pixel: a pix_valid in the same cycle as frame_start uses the newly latched source and is accepted as pixel (0,0).
- ACTIVE, pix_valid=1 (accept):
  - register wr_en=1, wr_addr=current address, wr_data=pix_data
  - advance: if x<COLS-1 then x+1, addr+1; else x=0, y+1, addr += FB_COLS−COLS+1
- Last pixel: accepting (COLS-1, ROWS-1) goes to DONE.
- DONE, one cycle:
  - frame_done=1, frame_cnt+1
  - then IDLE, or directly ACTIVE if frame_start=1 in this cycle (same latch rules as IDLE)
- ACTIVE, frame_start=1 (truncated frame):
  - restart at (0,0), A0, relatch bypass_act, set short_frame=1
  - no frame_done, frame_cnt unchanged
  - a coincident pix_valid is accepted as the new (0,0)
- Pixels arriving in IDLE, or in DONE without frame_start, are dropped: wr_en=0.
- short_frame clears only on reset.
- Width rules:
  - x is clog2(COLS) bits; y is clog2(ROWS) bits.
  - The address is AW bits unsigned.
  - Elaboration-time checks: X_OFF+COLS ≤ FB_COLS, and (Y_OFF+ROWS)·FB_COLS ≤ 2^AW.
- Reset mid-frame: all state returns to reset values next edge; no partial write follows the reset.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, bypass_act=0, busy=0, frame_done=0, short_frame=0, frame_cnt=0.
- Latency: accepted pixel at edge N → wr_en/wr_addr/wr_data valid in cycle N+1. Outputs are fully registered.
- wr_en is high for exactly one cycle per accepted pixel; back-to-back every cycle is supported.
- The cycle after the final accept has both wr_en=1 (last pixel) and frame_done=1.
- busy rises the cycle after frame_start. It falls in the same cycle frame_done rises, unless DONE chains directly to ACTIVE, in which case busy re-rises the following cycle.
- There is no backpressure: the RAM port is assumed always ready.

## Test plan
- Default params, frame_start, then 76800 contiguous cam_valid with bypass_req=1:
  - first write addr 76960
  - pixel (319,0) → 77279; pixel (0,1) → 77600
  - last write addr 230239
  - frame_done one pulse, frame_cnt=1, bypass_act=1
- bypass_req=0 with both sources toggling and different data: only flt_data is written. Change bypass_req mid-frame: no effect until the next frame_start.
- frame_start after 1000 pixels: short_frame=1, next write addr 76960, frame_cnt unchanged, no frame_done.
- pix_valid before any frame_start, and after frame_done without a new start: no wr_en. A pixel coincident with frame_start → written at 76960.
- frame_start in the DONE cycle with valid every cycle: second frame starts with no gap, both frames complete, frame_cnt=2.
- rstMain asserted mid-frame: all outputs return to reset values next cycle. After release, a new frame starts cleanly at 76960.
